wtm_pipe: RTL



---
 rtl/wtm_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/wtm_pipe.sv
// wtm_pipe: 3-stage pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH.
//   S1: partial-product array, S2: Wallace reduction to sum/carry rows,
//   S3: carry-propagate add plus overflow flag.
// Optional macro WTM_SIGNED_EN adds an is_signed input selecting two's-complement
// operands (Baugh-Wooley partial products); default build is unsigned-only.
module wtm_pipe #(
  parameter int unsigned WIDTH = 5
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
`ifdef WTM_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               ovf
);

  localparam int unsigned PW = 2 * WIDTH;
  // Enough 3:2 layers to bring 32 rows down to 2; spare layers pass through.
  localparam int unsigned NL = 8;

  // Number of rows entering reduction layer l.
  function automatic int unsigned rows_at(input int unsigned l);
    int unsigned n;
    n = WIDTH;
    for (int unsigned k = 0; k < l; k++) begin
      if (n > 2) n = (n / 3) * 2 + (n % 3);
    end
    return n;
  endfunction

  logic              v1, v2, v3;
  logic              en1, en2, en3;
  logic [PW-1:0]     pp_d [WIDTH];
  logic [PW-1:0]     pp_q [WIDTH];
  logic [PW-1:0]     lay  [NL+1][WIDTH];
  logic [PW-1:0]     sum_q, carry_q;
  logic [PW-1:0]     full;
  logic              ovf_d;
`ifdef WTM_SIGNED_EN
  logic              sg1, sg2;
`endif

  // Stage enables: a stage advances when empty or when its successor advances.
  always_comb begin
    en3      = !v3 || out_ready;
    en2      = !v2 || en3;
    en1      = !v1 || en2;
    in_ready = en1;
  end

  assign out_valid = v3;

  // Partial-product rows; signed mode inverts the terms that involve exactly one
  // operand MSB and folds the two correction constants into free row bits.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pp_d[i] = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
`ifdef WTM_SIGNED_EN
        pp_d[i][i+j] = (in1[j] & in2[i]) ^
                       (is_signed && ((i == WIDTH-1) != (j == WIDTH-1)));
`else
        pp_d[i][i+j] = in1[j] & in2[i];
`endif
      end
    end
`ifdef WTM_SIGNED_EN
    if (is_signed) begin
      pp_d[0][WIDTH]        = 1'b1;
      pp_d[WIDTH-1][PW-1]   = 1'b1;
    end
`endif
  end

  // Wallace tree: each layer groups rows in threes (3:2), a leftover pair goes
  // through a 2:2 compressor, a lone leftover row passes unchanged.
  for (genvar o = 0; o < WIDTH; o++) begin : g_l0
    assign lay[0][o] = pp_q[o];
  end

  for (genvar l = 0; l < NL; l++) begin : g_layer
    localparam int unsigned N = rows_at(l);
    localparam int unsigned F = N / 3;
    localparam int unsigned R = N % 3;
    for (genvar o = 0; o < WIDTH; o++) begin : g_row
      if (N <= 2) begin : g_pass
        if (o < N) begin : g_keep
          assign lay[l+1][o] = lay[l][o];
        end else begin : g_zero
          assign lay[l+1][o] = '0;
        end
      end else if (o / 2 < F) begin : g_fa
        localparam int unsigned B = 3 * (o / 2);
        if (o % 2 == 0) begin : g_sum
          assign lay[l+1][o] = lay[l][B] ^ lay[l][B+1] ^ lay[l][B+2];
        end else begin : g_cry
          assign lay[l+1][o] = ((lay[l][B]   & lay[l][B+1]) |
                                (lay[l][B]   & lay[l][B+2]) |
                                (lay[l][B+1] & lay[l][B+2])) << 1;
        end
      end else if (R == 2 && o == 2 * F) begin : g_hsum
        assign lay[l+1][o] = lay[l][3*F] ^ lay[l][3*F+1];
      end else if (R == 2 && o == 2 * F + 1) begin : g_hcry
        assign lay[l+1][o] = (lay[l][3*F] & lay[l][3*F+1]) << 1;
      end else if (R == 1 && o == 2 * F) begin : g_one
        assign lay[l+1][o] = lay[l][3*F];
      end else begin : g_none
        assign lay[l+1][o] = '0;
      end
    end
  end

  // Final carry-propagate add and overflow detection.
  always_comb begin
    full  = sum_q + carry_q;
    ovf_d = |full[PW-1:WIDTH];
`ifdef WTM_SIGNED_EN
    if (sg2) ovf_d = !((&full[PW-1:WIDTH-1]) || !(|full[PW-1:WIDTH-1]));
`endif
  end

  // Stage valid bits; cleared asynchronously so in-flight work is discarded.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  // Stage data registers; each loads only when a valid item moves into it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < WIDTH; i++) pp_q[i] <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      out     <= '0;
      ovf     <= 1'b0;
`ifdef WTM_SIGNED_EN
      sg1     <= 1'b0;
      sg2     <= 1'b0;
`endif
    end else begin
      if (en1 && in_valid) begin
        for (int unsigned i = 0; i < WIDTH; i++) pp_q[i] <= pp_d[i];
`ifdef WTM_SIGNED_EN
        sg1 <= is_signed;
`endif
      end
      if (en2 && v1) begin
        sum_q   <= lay[NL][0];
        carry_q <= lay[NL][1];
`ifdef WTM_SIGNED_EN
        sg2     <= sg1;
`endif
      end
      if (en3 && v2) begin
        out <= full;
        ovf <= ovf_d;
      end
    end
  end

endmodule
